// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-stage synchroniser for an asynchronous single-bit input.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start-bit glitch rejection, configurable width,
// parity and stop bits; one-cycle strobe with parity/framing error flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned PACK_SIZE   = 8,
    parameter parity_e     PARITY      = PAR_NONE,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_bit,
    output logic                 rx_byte_valid,
    output logic [PACK_SIZE-1:0] rx_byte_data,
    output logic                 rx_active,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned HALF         = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned TICK_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(PACK_SIZE + 1);

    // Tick is 0 in the first cycle after each restart, so a sample due N
    // cycles later fires when tick reaches N-1.
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_START = TICK_W'(HALF - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(PACK_SIZE - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || PACK_SIZE < 5 || PACK_SIZE > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
        $error("uart_rx_core: illegal configuration");
    end

    logic                 s;
    rx_state_e            state, state_nxt;
    logic [TICK_W-1:0]    tick, tick_nxt;
    logic [BIT_W-1:0]     cnt, cnt_nxt;
    logic [PACK_SIZE-1:0] shreg, shreg_nxt;
    logic                 armed, armed_nxt;
    logic                 par_acc, par_acc_nxt;
    logic                 par_err, par_err_nxt;
    logic                 frm_err, frm_err_nxt;
    logic                 sample;
    logic                 done;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_bit),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RX_IDLE;
            tick          <= '0;
            cnt           <= '0;
            shreg         <= '0;
            armed         <= 1'b0;
            par_acc       <= 1'b0;
            par_err       <= 1'b0;
            frm_err       <= 1'b0;
            rx_byte_valid <= 1'b0;
            rx_byte_data  <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            state         <= state_nxt;
            tick          <= tick_nxt;
            cnt           <= cnt_nxt;
            shreg         <= shreg_nxt;
            armed         <= armed_nxt;
            par_acc       <= par_acc_nxt;
            par_err       <= par_err_nxt;
            frm_err       <= frm_err_nxt;
            rx_byte_valid <= done;
            rx_parity_err <= done & par_err_nxt;
            rx_frame_err  <= done & frm_err_nxt;
            if (done) begin
                rx_byte_data <= shreg_nxt;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick + 1'b1;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        armed_nxt   = armed;
        par_acc_nxt = par_acc;
        par_err_nxt = par_err;
        frm_err_nxt = frm_err;
        done        = 1'b0;
        sample      = (tick == TICK_LAST);

        unique case (state)
            RX_IDLE: begin
                // Re-arm only once the line has been seen high, so a held-low
                // line cannot start a second frame.
                tick_nxt  = '0;
                armed_nxt = s;
                if (armed && !s) begin
                    state_nxt   = RX_START;
                    cnt_nxt     = '0;
                    armed_nxt   = 1'b0;
                    par_acc_nxt = 1'b0;
                    par_err_nxt = 1'b0;
                    frm_err_nxt = 1'b0;
                end
            end
            RX_START: begin
                if (tick == TICK_START) begin
                    tick_nxt  = '0;
                    state_nxt = s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (sample) begin
                    tick_nxt    = '0;
                    shreg_nxt   = {s, shreg[PACK_SIZE-1:1]};
                    par_acc_nxt = par_acc ^ s;
                    if (cnt == DATA_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (sample) begin
                    tick_nxt  = '0;
                    state_nxt = RX_STOP;
                    if ((par_acc ^ s) != (PARITY == PAR_ODD)) begin
                        par_err_nxt = 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (sample) begin
                    tick_nxt = '0;
                    if (!s) begin
                        frm_err_nxt = 1'b1;
                    end
                    if (cnt == STOP_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = RX_IDLE;
                        done      = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign rx_active = (state != RX_IDLE) || rx_byte_valid;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: four receiver configurations driven
// with directed and random frames, compared against a frame-level event model.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int unsigned CPB  = 8_000_000 / 1_000_000;
    localparam int unsigned HALF = (CPB - 1) / 2;
    localparam int unsigned NI   = 4;
    localparam int unsigned PS_T [NI] = '{8, 8, 8, 9};
    localparam parity_e     PR_T [NI] = '{PAR_NONE, PAR_EVEN, PAR_NONE, PAR_ODD};
    localparam int unsigned SB_T [NI] = '{1, 1, 2, 1};

    localparam int unsigned EV_STROBE = 0;
    localparam int unsigned EV_RISE   = 1;
    localparam int unsigned EV_FALL   = 2;

    typedef struct {
        int unsigned inst;
        int unsigned edge_no;
        int unsigned kind;
        int unsigned data;
        int unsigned pe;
        int unsigned fe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line [NI];
    logic       valid   [NI];
    logic       active  [NI];
    logic       perr    [NI];
    logic       ferr    [NI];
    logic [8:0] data    [NI];
    logic       act_prev [NI];

    int unsigned edge_cnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned last_data [NI];
    ev_t         obs_q[$];
    ev_t         exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [PS_T[g]-1:0] d;
        uart_rx_core #(
            .CLK_FREQ_HZ (8_000_000),
            .BAUD_RATE   (1_000_000),
            .PACK_SIZE   (PS_T[g]),
            .PARITY      (PR_T[g]),
            .STOP_BITS   (SB_T[g])
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .rx_bit        (rx_line[g]),
            .rx_byte_valid (valid[g]),
            .rx_byte_data  (d),
            .rx_active     (active[g]),
            .rx_parity_err (perr[g]),
            .rx_frame_err  (ferr[g])
        );
        assign data[g] = 9'(d);
    end

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic ev_t mk_ev(input int unsigned inst, input int unsigned e,
                                  input int unsigned kind, input int unsigned d,
                                  input int unsigned pe, input int unsigned fe);
        ev_t ev;
        ev.inst = inst; ev.edge_no = e; ev.kind = kind;
        ev.data = d;    ev.pe = pe;     ev.fe = fe;
        return ev;
    endfunction

    // Observe strobes and rx_active transitions; flags must be quiet between strobes.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (active[i] != act_prev[i])
                obs_q.push_back(mk_ev(i, edge_cnt, active[i] ? EV_RISE : EV_FALL, 0, 0, 0));
            act_prev[i] <= active[i];
            if (valid[i])
                obs_q.push_back(mk_ev(i, edge_cnt, EV_STROBE, data[i], perr[i], ferr[i]));
            else if (!rst)
                check_eq($sformatf("flags_idle%0d", i), {perr[i], ferr[i]}, 0);
        end
    end

    task automatic drive(input int unsigned inst, input logic v, input int unsigned cycles);
        rx_line[inst] = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Transmit one frame and record the events the receiver should produce:
    // start edge first sampled at edge p, k-th sample lands at p+1+HALF+k*CPB.
    task automatic send_frame(input int unsigned inst, input int unsigned din,
                              input logic pb, input logic [1:0] sl);
        int unsigned ps, n, p, dat, ones, pe, fe, s_edge;
        ps  = PS_T[inst];
        dat = din & ((32'd1 << ps) - 1);
        n   = ps + ((PR_T[inst] != PAR_NONE) ? 1 : 0) + SB_T[inst];
        p   = edge_cnt + 1;
        drive(inst, 1'b0, CPB);
        for (int b = 0; b < int'(ps); b++) drive(inst, 1'(dat >> b), CPB);
        if (PR_T[inst] != PAR_NONE) drive(inst, pb, CPB);
        for (int k = 0; k < int'(SB_T[inst]); k++) drive(inst, ~sl[k], CPB);
        ones = $countones(dat) + pb;
        if (PR_T[inst] == PAR_NONE)      pe = 0;
        else if (PR_T[inst] == PAR_EVEN) pe = ones % 2;
        else                             pe = 1 - ones % 2;
        fe = (sl[0] || (SB_T[inst] == 2 && sl[1])) ? 1 : 0;
        s_edge = p + 2 + HALF + n * CPB;
        exp_q.push_back(mk_ev(inst, p + 2, EV_RISE, 0, 0, 0));
        exp_q.push_back(mk_ev(inst, s_edge, EV_STROBE, dat, pe, fe));
        exp_q.push_back(mk_ev(inst, s_edge + 1, EV_FALL, 0, 0, 0));
        last_data[inst] = dat;
    endtask

    task automatic glitch(input int unsigned inst, input int unsigned len);
        int unsigned p;
        p = edge_cnt + 1;
        drive(inst, 1'b0, len);
        drive(inst, 1'b1, 4 * CPB);
        exp_q.push_back(mk_ev(inst, p + 2, EV_RISE, 0, 0, 0));
        exp_q.push_back(mk_ev(inst, p + 2 + HALF, EV_FALL, 0, 0, 0));
    endtask

    task automatic compare_events(input string tag, input int unsigned inst);
        check_eq({tag, ".count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_eq($sformatf("%s[%0d].inst", tag, i), obs_q[i].inst,    exp_q[i].inst);
            check_eq($sformatf("%s[%0d].edge", tag, i), obs_q[i].edge_no, exp_q[i].edge_no);
            check_eq($sformatf("%s[%0d].kind", tag, i), obs_q[i].kind,    exp_q[i].kind);
            check_eq($sformatf("%s[%0d].data", tag, i), obs_q[i].data,    exp_q[i].data);
            check_eq($sformatf("%s[%0d].pe",   tag, i), obs_q[i].pe,      exp_q[i].pe);
            check_eq($sformatf("%s[%0d].fe",   tag, i), obs_q[i].fe,      exp_q[i].fe);
        end
        check_eq({tag, ".hold"}, data[inst], last_data[inst]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned r_edge, dat;
        logic        pb;
        logic [1:0]  sl;

        for (int i = 0; i < NI; i++) begin
            rx_line[i]   = 1'b1;
            act_prev[i]  = 1'b0;
            last_data[i] = 0;
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("reset.valid%0d",  i), valid[i],  0);
            check_eq($sformatf("reset.data%0d",   i), data[i],   0);
            check_eq($sformatf("reset.active%0d", i), active[i], 0);
            check_eq($sformatf("reset.perr%0d",   i), perr[i],   0);
            check_eq($sformatf("reset.ferr%0d",   i), ferr[i],   0);
        end
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        obs_q.delete();

        send_frame(0, 'hA5, 1'b0, 2'b00);
        drive(0, 1'b1, 2 * CPB);
        compare_events("8n1_a5", 0);

        glitch(0, 3);
        compare_events("glitch3", 0);

        send_frame(1, 'h03, 1'b1, 2'b00);
        drive(1, 1'b1, CPB);
        send_frame(1, 'h03, 1'b0, 2'b00);
        drive(1, 1'b1, 2 * CPB);
        compare_events("8e1_par", 1);

        send_frame(2, 'h5A, 1'b0, 2'b10);
        drive(2, 1'b0, 50 * CPB);
        drive(2, 1'b1, 2 * CPB);
        send_frame(2, 'hC3, 1'b0, 2'b00);
        drive(2, 1'b1, 2 * CPB);
        compare_events("8n2_break", 2);

        send_frame(3, 'h1FF, 1'b0, 2'b00);
        send_frame(3, 'h000, 1'b1, 2'b00);
        drive(3, 1'b1, 2 * CPB);
        if (obs_q.size() >= 5)
            check_eq("b2b.spacing", obs_q[4].edge_no - obs_q[1].edge_no, 12 * CPB);
        else
            check_eq("b2b.events", obs_q.size(), 6);
        compare_events("9o1_b2b", 3);

        for (int inst = 0; inst < int'(NI); inst++) begin
            for (int f = 0; f < 6; f++) begin
                dat = $urandom;
                pb  = 1'($urandom % 2);
                sl  = 2'b00;
                if ($urandom % 8 == 0) sl[0] = 1'b1;
                if (SB_T[inst] == 2 && $urandom % 8 == 0) sl[1] = 1'b1;
                send_frame(inst, dat, pb, sl);
                if (sl[SB_T[inst] - 1])
                    drive(inst, 1'b1, CPB + $urandom % CPB);
                else
                    drive(inst, 1'b1, $urandom % (2 * CPB));
                if ($urandom % 4 == 0) glitch(inst, 1 + $urandom % HALF);
            end
            drive(inst, 1'b1, 2 * CPB);
            compare_events($sformatf("rand%0d", inst), inst);
        end

        send_frame(0, 'h3C, 1'b0, 2'b00);
        drive(0, 1'b1, 2 * CPB);
        compare_events("pre_rst", 0);
        r_edge = edge_cnt + 1;
        exp_q.push_back(mk_ev(0, r_edge + 2, EV_RISE, 0, 0, 0));
        drive(0, 1'b0, CPB);
        for (int b = 0; b < 3; b++) drive(0, 1'(8'h77 >> b), CPB);
        rst = 1'b1;
        rx_line[0] = 1'b1;
        r_edge = edge_cnt + 1;
        @(negedge clk);
        check_eq("midrst.valid",  valid[0],  0);
        check_eq("midrst.data",   data[0],   0);
        check_eq("midrst.active", active[0], 0);
        check_eq("midrst.perr",   perr[0],   0);
        check_eq("midrst.ferr",   ferr[0],   0);
        exp_q.push_back(mk_ev(0, r_edge, EV_FALL, 0, 0, 0));
        for (int i = 0; i < NI; i++) last_data[i] = 0;
        rst = 1'b0;
        drive(0, 1'b1, 3 * CPB);
        send_frame(0, 'h12, 1'b0, 2'b00);
        drive(0, 1'b1, 2 * CPB);
        compare_events("post_rst", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
